// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command sequencer and statistics front end for the registered ALU
module alu_cmd_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_cmd_arg0,
    input  logic [WIDTH-1:0] i_cmd_arg1,
    input  logic [1:0]       i_cmd_oper,
    output logic [WIDTH-1:0] o_alu_arg0,
    output logic [WIDTH-1:0] o_alu_arg1,
    output logic [1:0]       o_alu_oper,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [2:0]       i_alu_flag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [2:0]       o_rsp_flag,
    output logic [CNT_W-1:0] o_op_count,
    output logic [CNT_W-1:0] o_ovf_count,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic   cmd_fire;
    logic   rsp_fire;

    // Ready is gated by reset so a command presented during reset is never taken.
    assign o_cmd_ready = (state == IDLE) && i_RSTn;
    assign o_busy      = (state != IDLE);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign rsp_fire    = o_rsp_valid && i_rsp_ready;

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = EXEC;
            EXEC:    state_next = CAPT;
            CAPT:    state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            o_alu_arg0   <= '0;
            o_alu_arg1   <= '0;
            o_alu_oper   <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_flag   <= '0;
            o_op_count   <= '0;
            o_ovf_count  <= '0;
        end else begin
            if (cmd_fire) begin
                o_alu_arg0 <= i_cmd_arg0;
                o_alu_arg1 <= i_cmd_arg1;
                o_alu_oper <= i_cmd_oper;
            end
            // The ALU result register is valid one cycle after EXEC.
            if (state == CAPT) begin
                o_rsp_result <= i_alu_result;
                o_rsp_flag   <= i_alu_flag;
                o_rsp_valid  <= 1'b1;
            end
            if (rsp_fire) begin
                o_rsp_valid <= 1'b0;
                o_op_count  <= o_op_count + 1'b1;
                if (o_rsp_flag[0] && (o_ovf_count != {CNT_W{1'b1}})) begin
                    o_ovf_count <= o_ovf_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - scoreboard bench for alu_cmd_driver with a registered ALU model
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_arg0 = '0;
    logic [7:0]  cmd_arg1 = '0;
    logic [1:0]  cmd_oper = '0;
    logic [7:0]  alu_arg0;
    logic [7:0]  alu_arg1;
    logic [1:0]  alu_oper;
    logic [7:0]  alu_result;
    logic [2:0]  alu_flag;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_result;
    logic [2:0]  rsp_flag;
    logic [15:0] op_count;
    logic [15:0] ovf_count;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_hs = 0;
    int exp_op = 0;
    int exp_ovf = 0;
    logic prev_valid = 1'b0;
    logic cnt_pending = 1'b0;
    logic [10:0] exp_q[$];

    alu_cmd_driver #(.WIDTH(8), .CNT_W(16)) dut (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_arg0(cmd_arg0), .i_cmd_arg1(cmd_arg1), .i_cmd_oper(cmd_oper),
        .o_alu_arg0(alu_arg0), .o_alu_arg1(alu_arg1), .o_alu_oper(alu_oper),
        .i_alu_result(alu_result), .i_alu_flag(alu_flag),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_flag(rsp_flag),
        .o_op_count(op_count), .o_ovf_count(ovf_count), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU: flags are {zero, carry/borrow, signed overflow}.
    always @(posedge clk) begin
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        if (!rst_n) begin
            alu_result <= '0;
            alu_flag   <= '0;
        end else begin
            c = 1'b0;
            v = 1'b0;
            case (alu_oper)
                2'b00: begin
                    s = {1'b0, alu_arg0} + {1'b0, alu_arg1};
                    r = s[7:0]; c = s[8];
                    v = (alu_arg0[7] == alu_arg1[7]) && (r[7] != alu_arg0[7]);
                end
                2'b01: begin
                    s = {1'b0, alu_arg0} - {1'b0, alu_arg1};
                    r = s[7:0]; c = s[8];
                    v = (alu_arg0[7] != alu_arg1[7]) && (r[7] != alu_arg0[7]);
                end
                2'b10: r = alu_arg0 & alu_arg1;
                default: r = 8'($countones({alu_arg1, alu_arg0}));
            endcase
            alu_result <= r;
            alu_flag   <= {(r == 8'h00), c, v};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cnt_pending) begin
            chk("op_count", int'(op_count), exp_op);
            chk("ovf_count", int'(ovf_count), exp_ovf);
            cnt_pending = 1'b0;
        end
        if (rst_n && rsp_valid && !prev_valid)
            chk("rsp_latency", cyc - last_acc, 2);
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk("rsp_result", int'(rsp_result), int'(e[10:3]));
                chk("rsp_flag", int'(rsp_flag), int'(e[2:0]));
                exp_op = (exp_op + 1) % 65536;
                if (rsp_flag[0] && exp_ovf != 65535) exp_ovf++;
                last_hs = cyc + 1;
                cnt_pending = 1'b1;
            end
        end
        prev_valid = rsp_valid && rst_n;
    end

    task automatic send(input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] op,
                        input logic [7:0] er, input logic [2:0] ef);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_arg0 = a0; cmd_arg1 = a1; cmd_oper = op;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back({er, ef});
            last_acc = cyc + 1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int a1, a2, a3;
        logic [7:0] hold_res;
        logic [2:0] hold_flag;
        // Command offered during reset must not be taken.
        cmd_valid = 1'b1; cmd_arg0 = 8'h55; cmd_arg1 = 8'h55;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(rsp_valid), 0);
        chk("reset_alu_arg0", int'(alu_arg0), 0);
        chk("reset_ready", int'(cmd_ready), 1);

        rsp_ready = 1'b1;
        send(8'h7F, 8'h01, 2'b00, 8'h80, 3'b001);
        wait_idle();
        send(8'h00, 8'h01, 2'b01, 8'hFF, 3'b010);
        wait_idle();
        send(8'hF0, 8'h0F, 2'b10, 8'h00, 3'b100);
        wait_idle();
        send(8'hFF, 8'h01, 2'b11, 8'h09, 3'b000);
        wait_idle();
        chk("alu_hold_arg0", int'(alu_arg0), 8'hFF);
        chk("rsp_hold_result", int'(rsp_result), 8'h09);

        send(8'h10, 8'h20, 2'b00, 8'h30, 3'b000);
        a1 = last_acc;
        send(8'h05, 8'h03, 2'b01, 8'h02, 3'b000);
        a2 = last_acc;
        send(8'hFF, 8'hAA, 2'b10, 8'hAA, 3'b000);
        a3 = last_acc;
        chk("spacing_1", a2 - a1, 4);
        chk("spacing_2", a3 - a2, 4);
        wait_idle();
        chk("op_count_7", int'(op_count), 7);

        // Backpressure with a second command waiting.
        rsp_ready = 1'b0;
        send(8'h80, 8'h80, 2'b00, 8'h00, 3'b111);
        fork
            send(8'h00, 8'h00, 2'b11, 8'h00, 3'b100);
            begin
                int n;
                n = 0;
                while (!rsp_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                hold_res = rsp_result;
                hold_flag = rsp_flag;
                chk("bp_result_seen", int'(rsp_result), 8'h00);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_result", int'(rsp_result), int'(hold_res));
                    chk("bp_flag", int'(rsp_flag), int'(hold_flag));
                    chk("bp_ready", int'(cmd_ready), 0);
                    chk("bp_valid", int'(rsp_valid), 1);
                end
                rsp_ready = 1'b1;
            end
        join
        chk("accept_after_hs", last_acc - last_hs, 1);
        wait_idle();
        chk("ovf_count_2", int'(ovf_count), 2);

        // Reset while in EXEC.
        send(8'h7F, 8'h7F, 2'b00, 8'hFE, 3'b001);
        chk("in_exec_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        exp_op = 0;
        exp_ovf = 0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(rsp_valid), 0);
        chk("abort_op_count", int'(op_count), 0);
        chk("abort_ovf_count", int'(ovf_count), 0);
        chk("abort_alu_args", int'({alu_arg0, alu_arg1, alu_oper}), 0);
        repeat (10) @(negedge clk);
        chk("abort_no_rsp", int'(rsp_valid), 0);

        send(8'h01, 8'h02, 2'b00, 8'h03, 3'b000);
        wait_idle();
        chk("post_abort_count", int'(op_count), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
